// File: rtl/multichannel_delay_line_pkg.sv
// Shared constants, FSM state type and lane-extension helper for the
// multichannel delay line.
package multichannel_delay_line_pkg;

    localparam int DATA_SIZE     = 16;
    localparam int FULL_SIZE     = 24;
    localparam int CHANNELS      = 4;
    localparam int MAX_DEPTH     = 16;
    localparam int DEFAULT_DELAY = 4;
    localparam bit SIGN_EXTEND   = 1'b1;

    // Widest lane the extension helper can handle.
    localparam int EXT_MAX = 64;

    typedef enum logic {
        FILL,
        RUN
    } delay_state_t;

    // Extends the low data_size bits of data to EXT_MAX bits; callers slice
    // the result down to their output width.
    function automatic logic [EXT_MAX-1:0] extend_lane(
        input logic [EXT_MAX-1:0] data,
        input int                 data_size,
        input logic               sign_mode
    );
        logic [EXT_MAX-1:0] result;
        logic               msb;
        msb = 1'b0;
        for (int i = 0; i < EXT_MAX; i++) begin
            if (i == data_size - 1) msb = data[i];
        end
        for (int i = 0; i < EXT_MAX; i++) begin
            result[i] = (i < data_size) ? data[i] : (sign_mode & msb);
        end
        return result;
    endfunction

endpackage

// File: rtl/multichannel_delay_line_ram.sv
// Sample buffer: one write port, one registered read port. A read and a write
// to the same address in the same clock return the previous contents.
module delay_line_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 96,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/multichannel_delay_line.sv
// Multi-lane delay line whose depth is counted in accepted samples; the output
// is gated off while the buffer refills after reset or a delay change.
module multichannel_delay_line
    import multichannel_delay_line_pkg::*;
#(
    parameter int DATA_SIZE     = multichannel_delay_line_pkg::DATA_SIZE,
    parameter int FULL_SIZE     = multichannel_delay_line_pkg::FULL_SIZE,
    parameter int CHANNELS      = multichannel_delay_line_pkg::CHANNELS,
    parameter int MAX_DEPTH     = multichannel_delay_line_pkg::MAX_DEPTH,
    parameter int DEFAULT_DELAY = multichannel_delay_line_pkg::DEFAULT_DELAY,
    parameter bit SIGN_EXTEND   = multichannel_delay_line_pkg::SIGN_EXTEND
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CHANNELS*DATA_SIZE-1:0]    input_data,
    input  logic                             input_valid,
    input  logic                             enable,
    input  logic                             delay_load,
    input  logic [$clog2(MAX_DEPTH+1)-1:0]   delay_value,
    output logic [CHANNELS*FULL_SIZE-1:0]    output_data,
    output logic                             output_valid,
    output logic [$clog2(MAX_DEPTH+1)-1:0]   delay_current,
    output logic                             filling
);

    localparam int DW = $clog2(MAX_DEPTH + 1);
    localparam int PW = $clog2(MAX_DEPTH);
    localparam int WW = CHANNELS * FULL_SIZE;

    delay_state_t       state, state_n;
    logic [DW-1:0]      delay_q, delay_clamped;
    logic [DW-1:0]      fill_cnt, fill_n;
    logic [PW-1:0]      wr_ptr, rd_addr;
    logic [DW:0]        rd_sum;
    logic               rd_en;
    logic               en_q;
    logic [WW-1:0]      wr_word, rd_word;
    logic [EXT_MAX-1:0] lane_wide;

    always_comb begin
        delay_clamped = delay_value;
        if (delay_value == '0) begin
            delay_clamped = DW'(1);
        end else if (delay_value > DW'(MAX_DEPTH)) begin
            delay_clamped = DW'(MAX_DEPTH);
        end
    end

    always_comb begin
        wr_word   = '0;
        lane_wide = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            lane_wide = extend_lane(EXT_MAX'(input_data[c*DATA_SIZE +: DATA_SIZE]),
                                    DATA_SIZE, SIGN_EXTEND);
            wr_word[c*FULL_SIZE +: FULL_SIZE] = lane_wide[FULL_SIZE-1:0];
        end
    end

    // Oldest-sample address: wr_ptr - D modulo MAX_DEPTH, kept non-negative.
    always_comb begin
        rd_sum = (DW+1)'(wr_ptr) + (DW+1)'(MAX_DEPTH) - (DW+1)'(delay_q);
        if (rd_sum >= (DW+1)'(MAX_DEPTH)) begin
            rd_sum = rd_sum - (DW+1)'(MAX_DEPTH);
        end
        rd_addr = PW'(rd_sum);
    end

    always_comb begin
        state_n = state;
        fill_n  = fill_cnt;
        rd_en   = 1'b0;
        if (delay_load) begin
            // A sample arriving with the load is the first fill sample under the new D.
            state_n = FILL;
            fill_n  = '0;
            if (input_valid) begin
                if (delay_clamped == DW'(1)) begin
                    state_n = RUN;
                end else begin
                    fill_n = DW'(1);
                end
            end
        end else if (input_valid) begin
            case (state)
                FILL: begin
                    if (fill_cnt == delay_q - DW'(1)) begin
                        state_n = RUN;
                        fill_n  = '0;
                    end else begin
                        fill_n = fill_cnt + DW'(1);
                    end
                end
                RUN:     rd_en = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FILL;
            fill_cnt     <= '0;
            delay_q      <= DW'(DEFAULT_DELAY);
            wr_ptr       <= '0;
            output_valid <= 1'b0;
            en_q         <= 1'b0;
        end else begin
            state        <= state_n;
            fill_cnt     <= fill_n;
            output_valid <= rd_en;
            if (delay_load) delay_q <= delay_clamped;
            if (input_valid) begin
                wr_ptr <= (wr_ptr == PW'(MAX_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (rd_en) en_q <= enable;
        end
    end

    delay_line_ram #(
        .DEPTH (MAX_DEPTH),
        .WIDTH (WW),
        .AW    (PW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (input_valid & ~reset),
        .wr_addr (wr_ptr),
        .wr_data (wr_word),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_word)
    );

    // rd_word and en_q only change on read cycles, so the output holds otherwise.
    assign output_data   = en_q ? rd_word : '0;
    assign delay_current = delay_q;
    assign filling       = (state == FILL);

endmodule

// File: tb/tb_multichannel_delay_line.sv
// Directed bench for multichannel_delay_line: fill gating, delay reprogramming,
// clamping, gapped valid, enable gating, lane extension and mid-run reset.
module tb_multichannel_delay_line;

    logic        clk;
    logic        reset;
    logic [63:0] input_data;
    logic        input_valid;
    logic        enable;
    logic        delay_load;
    logic [4:0]  delay_value;
    logic [95:0] output_data;
    logic        output_valid;
    logic [4:0]  delay_current;
    logic        filling;
    logic [95:0] output_data_z;
    logic        output_valid_z;
    logic [4:0]  delay_current_z;
    logic        filling_z;

    int total;
    int passed;

    multichannel_delay_line dut (
        .clk           (clk),
        .reset         (reset),
        .input_data    (input_data),
        .input_valid   (input_valid),
        .enable        (enable),
        .delay_load    (delay_load),
        .delay_value   (delay_value),
        .output_data   (output_data),
        .output_valid  (output_valid),
        .delay_current (delay_current),
        .filling       (filling)
    );

    multichannel_delay_line #(.SIGN_EXTEND(1'b0)) dut_z (
        .clk           (clk),
        .reset         (reset),
        .input_data    (input_data),
        .input_valid   (input_valid),
        .enable        (enable),
        .delay_load    (delay_load),
        .delay_value   (delay_value),
        .output_data   (output_data_z),
        .output_valid  (output_valid_z),
        .delay_current (delay_current_z),
        .filling       (filling_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] all4(input logic [15:0] v);
        return {v, v, v, v};
    endfunction

    function automatic logic [95:0] exp4(input logic [15:0] v);
        logic [23:0] e;
        e = {8'h00, v};
        return {e, e, e, e};
    endfunction

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // One clock: apply inputs, take the edge, settle, clear strobes.
    task automatic cyc(input logic v, input logic [63:0] d, input logic en);
        input_valid = v;
        input_data  = d;
        enable      = en;
        @(posedge clk);
        #1;
        input_valid = 1'b0;
        delay_load  = 1'b0;
    endtask

    initial begin
        total       = 0;
        passed      = 0;
        reset       = 1'b1;
        input_data  = '0;
        input_valid = 1'b0;
        enable      = 1'b1;
        delay_load  = 1'b0;
        delay_value = '0;

        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1);
        chk("rst_valid", 96'(output_valid), 96'd0);
        chk("rst_data", output_data, 96'd0);
        chk("rst_delay", 96'(delay_current), 96'd4);
        chk("rst_filling", 96'(filling), 96'd1);
        chk("rst_delay_z", 96'(delay_current_z), 96'd4);
        chk("rst_filling_z", 96'(filling_z), 96'd1);
        reset = 1'b0;

        for (int v = 1; v <= 10; v++) begin
            cyc(1'b1, all4(16'(v)), 1'b1);
            if (v <= 4) begin
                chk("ramp_fill_silent", 96'(output_valid), 96'd0);
                chk("ramp_filling", 96'(filling), 96'(v < 4));
            end else begin
                chk("ramp_valid", 96'(output_valid), 96'd1);
                chk("ramp_data", output_data, exp4(16'(v - 4)));
            end
        end

        // Sample 11: lane 2 carries the most negative value.
        cyc(1'b1, {16'd11, 16'h8000, 16'd11, 16'd11}, 1'b1);
        chk("sx_pre_data", output_data, exp4(16'd7));
        for (int v = 12; v <= 14; v++) begin
            cyc(1'b1, all4(16'(v)), 1'b1);
            chk("sx_mid_data", output_data, exp4(16'(v - 4)));
        end
        cyc(1'b1, all4(16'd15), 1'b1);
        chk("sx_lane2_signed", 96'(output_data[71:48]), 96'h00FF8000);
        chk("sx_lane0_signed", 96'(output_data[23:0]), 96'h0000000B);
        chk("sx_lane2_zero", 96'(output_data_z[71:48]), 96'h00008000);
        chk("sx_valid_zero", 96'(output_valid_z), 96'd1);

        cyc(1'b1, all4(16'd16), 1'b0);
        chk("en0_valid", 96'(output_valid), 96'd1);
        chk("en0_data", output_data, 96'd0);
        cyc(1'b1, all4(16'd17), 1'b0);
        chk("en0_valid2", 96'(output_valid), 96'd1);
        chk("en0_data2", output_data, 96'd0);
        cyc(1'b1, all4(16'd18), 1'b1);
        chk("en1_resume", output_data, exp4(16'd14));
        cyc(1'b1, all4(16'd19), 1'b1);
        chk("en1_resume2", output_data, exp4(16'd15));

        delay_load  = 1'b1;
        delay_value = 5'd3;
        cyc(1'b0, '0, 1'b1);
        chk("d3_current", 96'(delay_current), 96'd3);
        chk("d3_filling", 96'(filling), 96'd1);
        chk("d3_silent", 96'(output_valid), 96'd0);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, all4(16'(101 + k)), 1'b1);
            if (k < 3) begin
                chk("gap_fill_silent", 96'(output_valid), 96'd0);
            end else begin
                chk("gap_valid", 96'(output_valid), 96'd1);
                chk("gap_data", output_data, exp4(16'(98 + k)));
            end
            for (int g = 0; g < 3; g++) begin
                cyc(1'b0, '0, 1'b1);
                chk("gap_idle_silent", 96'(output_valid), 96'd0);
                if (k == 3) chk("gap_hold", output_data, exp4(16'd101));
            end
        end

        delay_load  = 1'b1;
        delay_value = 5'd0;
        cyc(1'b1, all4(16'd200), 1'b1);
        chk("d1_load_silent", 96'(output_valid), 96'd0);
        chk("d1_current", 96'(delay_current), 96'd1);
        chk("d1_run_now", 96'(filling), 96'd0);
        cyc(1'b1, all4(16'd201), 1'b1);
        chk("d1_data", output_data, exp4(16'd200));
        cyc(1'b1, all4(16'd202), 1'b1);
        chk("d1_data2", output_data, exp4(16'd201));

        delay_load  = 1'b1;
        delay_value = 5'd31;
        cyc(1'b0, '0, 1'b1);
        chk("d16_current", 96'(delay_current), 96'd16);
        chk("d16_filling", 96'(filling), 96'd1);
        for (int i = 0; i <= 16; i++) begin
            cyc(1'b1, all4(16'(300 + i)), 1'b1);
            if (i < 16) chk("d16_silent", 96'(output_valid), 96'd0);
            if (i == 14) chk("d16_still_filling", 96'(filling), 96'd1);
            if (i == 15) chk("d16_run", 96'(filling), 96'd0);
            if (i == 16) begin
                chk("d16_valid", 96'(output_valid), 96'd1);
                chk("d16_data", output_data, exp4(16'd300));
            end
        end

        // Reset wins over a simultaneous load and sample.
        reset       = 1'b1;
        delay_load  = 1'b1;
        delay_value = 5'd7;
        cyc(1'b1, all4(16'd317), 1'b1);
        reset = 1'b0;
        chk("rr_valid", 96'(output_valid), 96'd0);
        chk("rr_data", output_data, 96'd0);
        chk("rr_delay", 96'(delay_current), 96'd4);
        chk("rr_filling", 96'(filling), 96'd1);
        for (int v = 1; v <= 7; v++) begin
            cyc(1'b1, all4(16'(v)), 1'b1);
            if (v <= 4) begin
                chk("rr_fill_silent", 96'(output_valid), 96'd0);
            end else begin
                chk("rr_ramp_valid", 96'(output_valid), 96'd1);
                chk("rr_ramp_data", output_data, exp4(16'(v - 4)));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
